regfile_dump_unit: RTL and testbench
====================================

Name: regfile_dump_unit

Overview:
- Debug read-out engine for the pipelined CPU in `top`.
- When a PC breakpoint matches, or on a manual request, it freezes the pipeline by asserting `halt`.
- It then reads every register-file entry in index order and streams each one out over a valid/ready interface.
- After the last word it holds the CPU halted until `resume` arrives; benches and host logic use it to read state out of the core.

Parameters:
- DATA_W, 16, register word width.
- PC_W, 16, width of the PC and of the breakpoint address.
- NUM_REGS, 16, number of register-file entries dumped.
- IDX_W, 4, register index width; must satisfy 2**IDX_W >= NUM_REGS.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- bp_en  input  1  breakpoint enable.
- bp_addr  input  PC_W  breakpoint address.
- pc_next  input  PC_W  next-PC value from the core.
- dump_req  input  1  manual dump request; single-cycle pulse or level.
- resume  input  1  release request after the dump completes.
- halt  output  1  pipeline stall/freeze request to the core.
- rf_rd_idx  output  IDX_W  register-file read index; the register file reads combinationally.
- rf_rd_data  input  DATA_W  register-file read data for rf_rd_idx, same cycle.
- dump_valid  output  1  output word valid.
- dump_ready  input  1  downstream accepts the word.
- dump_data  output  DATA_W  register value.
- dump_idx  output  IDX_W  index of the register in dump_data.
- dump_last  output  1  marks the word for index NUM_REGS-1.
- done  output  1  dump complete; waiting for resume.

Behaviour:
- Clock and reset:
  - Single clock domain; every state change happens on the rising edge of clk.
  - rst is synchronous, active-high.
  - Reset values: halt=0, dump_valid=0, dump_data=0, dump_idx=0, dump_last=0, done=0, rf_rd_idx=0, state=IDLE, cnt=0, armed=1.
- States: IDLE, DUMP, WAIT_RESUME.
- Trigger:
  - Condition: in IDLE, (bp_en && armed && pc_next==bp_addr) || dump_req, sampled at edge T.
  - At T: state<=DUMP, halt<=1, cnt<=0, armed<=0.
- Re-arming: armed returns to 1 in any cycle where pc_next != bp_addr. This prevents an immediate retrigger after resume at the same PC.
- DUMP, output holding register empty (dump_valid=0, or the current word accepted this cycle):
  - rf_rd_idx=cnt.
  - Next edge: dump_data<=rf_rd_data, dump_idx<=cnt, dump_last<=(cnt==NUM_REGS-1), dump_valid<=1, cnt<=cnt+1.
- Latency:
  - First word is valid at T+2.
  - With dump_ready held high, one word per cycle and no bubbles; the full dump spans NUM_REGS consecutive valid cycles.
- Handshake:
  - A word transfers on a rising edge where dump_valid && dump_ready.
  - While dump_valid=1 && dump_ready=0, dump_data/dump_idx/dump_last hold stable and cnt does not advance.
  - dump_valid never deasserts without a transfer.
- Last word:
  - On transfer of the word with dump_last=1: dump_valid<=0, dump_last<=0, state<=WAIT_RESUME, done<=1.
  - cnt never loads beyond NUM_REGS-1; no wrap-around read of index 0.
- WAIT_RESUME:
  - halt=1 and done=1.
  - On resume=1: state<=IDLE, halt<=0, done<=0 at the next edge.
- Ignored events:
  - resume in IDLE or DUMP is ignored.
  - dump_req or a breakpoint match in DUMP or WAIT_RESUME is ignored.
  - Changes to bp_en or bp_addr during DUMP are ignored.
- Simultaneous events: if resume and a breakpoint match occur in the same cycle in WAIT_RESUME, resume wins; the match is not re-evaluated until IDLE.
- halt timing: halt is registered and remains 1 continuously from T+1 until the edge after resume is accepted.
- Reset mid-operation: rst in any state returns all state to reset values at the next edge. The partial dump is abandoned, dump_valid drops, and halt releases.
- Width rules:
  - pc_next and bp_addr are compared over the full PC_W bits, unsigned equality.
  - dump_idx is zero-extended cnt.

Test Plan:
- Breakpoint dump, ready always high:
  - Setup: regs[i]=16'h1000+i, bp_en=1, bp_addr=50, pc_next reaches 50 at edge T.
  - Required: halt=1 at T+1; dump_valid high T+2..T+17 with dump_data 1000..100F and dump_idx 0..15; dump_last only at idx 15; done=1 at T+18.
- Backpressure:
  - Stimulus: dump_ready low for 3 cycles while idx 4 (16'h1004) is presented.
  - Required: data and idx held stable; no word skipped or duplicated; 16 transfers total.
- Resume and re-arm:
  - Stimulus: pulse resume in WAIT_RESUME while pc_next stays 50.
  - Required: halt=0 next edge, no retrigger; after pc_next moves to 52 and back to 50, a second full dump occurs.
- Manual request: bp_en=0, one-cycle dump_req pulse -> full 16-word dump; resume pulses issued during DUMP are ignored.
- Reset mid-dump:
  - Stimulus: assert rst after idx 7 transfers.
  - Required: next edge halt=0, dump_valid=0, done=0, state IDLE; a subsequent dump_req restarts at idx 0.
- Disabled breakpoint: bp_en=0 with pc_next=bp_addr=50 for 10 cycles -> halt stays 0 and dump_valid stays 0.

Source files
------------

// File: rtl/regfile_dump_unit.sv
// Debug read-out engine: halts the core on a PC breakpoint or a manual
// request, streams every register-file entry out over valid/ready in index
// order, then keeps the core halted until resume.
//
//  state       | meaning
//  ------------+-----------------------------------------------------------
//  IDLE        | core running; watching for breakpoint match or dump_req
//  DUMP        | core halted; reading registers and streaming them out
//  WAIT_RESUME | dump finished; core still halted, done=1, waiting resume
module regfile_dump_unit #(
    parameter int DATA_W   = 16,
    parameter int PC_W     = 16,
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic [PC_W-1:0]   pc_next,
    input  logic              dump_req,
    input  logic              resume,
    output logic              halt,
    output logic [IDX_W-1:0]  rf_rd_idx,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [IDX_W-1:0]  dump_idx,
    output logic              dump_last,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DUMP        = 2'd1,
        WAIT_RESUME = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] cnt;
    logic             armed;
    logic             pc_hit;
    logic             xfer;
    logic             trigger;
    logic             load_word;
    logic             xfer_last;
    logic             release_core;

    assign pc_hit    = (pc_next == bp_addr);
    assign xfer      = dump_valid && dump_ready;
    // The register file is read combinationally at the next index to load.
    assign rf_rd_idx = cnt;

    // Next-state and per-cycle control decisions.
    always_comb begin
        state_nxt    = state;
        trigger      = 1'b0;
        load_word    = 1'b0;
        xfer_last    = 1'b0;
        release_core = 1'b0;
        case (state)
            IDLE: begin
                if ((bp_en && armed && pc_hit) || dump_req) begin
                    trigger   = 1'b1;
                    state_nxt = DUMP;
                end
            end
            DUMP: begin
                // A pending last word blocks further loads, so cnt never
                // wraps back to index 0.
                if (xfer && dump_last) begin
                    xfer_last = 1'b1;
                    state_nxt = WAIT_RESUME;
                end else if (!dump_valid || dump_ready) begin
                    load_word = 1'b1;
                end
            end
            WAIT_RESUME: begin
                if (resume) begin
                    release_core = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Index counter, breakpoint arming, halt/done flags and output holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            armed      <= 1'b1;
            halt       <= 1'b0;
            done       <= 1'b0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_idx   <= '0;
            dump_last  <= 1'b0;
        end else begin
            // Moving off the breakpoint PC re-arms it, so resuming at the
            // same PC does not immediately retrigger.
            if (!pc_hit) begin
                armed <= 1'b1;
            end else if (trigger) begin
                armed <= 1'b0;
            end

            if (trigger) begin
                halt <= 1'b1;
                cnt  <= '0;
            end

            if (load_word) begin
                dump_data  <= rf_rd_data;
                dump_idx   <= cnt;
                dump_last  <= (cnt == LAST_IDX);
                dump_valid <= 1'b1;
                if (cnt != LAST_IDX) begin
                    cnt <= cnt + 1'b1;
                end
            end

            if (xfer_last) begin
                dump_valid <= 1'b0;
                dump_last  <= 1'b0;
                done       <= 1'b1;
            end

            if (release_core) begin
                halt <= 1'b0;
                done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Scoreboard bench for regfile_dump_unit: the stimulus thread pushes the
// expected word stream for every dump it starts; a negedge monitor pops and
// compares on each transfer and checks hold-stability under backpressure.
module tb_regfile_dump_unit;

    localparam int DATA_W   = 16;
    localparam int PC_W     = 16;
    localparam int NUM_REGS = 16;
    localparam int IDX_W    = 4;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  idx;
        logic              last;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              bp_en;
    logic [PC_W-1:0]   bp_addr;
    logic [PC_W-1:0]   pc_next;
    logic              dump_req;
    logic              resume;
    logic              halt;
    logic [IDX_W-1:0]  rf_rd_idx;
    logic [DATA_W-1:0] rf_rd_data;
    logic              dump_valid;
    logic              dump_ready;
    logic [DATA_W-1:0] dump_data;
    logic [IDX_W-1:0]  dump_idx;
    logic              dump_last;
    logic              done;

    logic [DATA_W-1:0] regs [NUM_REGS];
    exp_t              expq [$];
    int                checks = 0;
    int                errors = 0;
    int                xfer_count = 0;

    regfile_dump_unit #(
        .DATA_W(DATA_W), .PC_W(PC_W), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .bp_en(bp_en), .bp_addr(bp_addr),
        .pc_next(pc_next), .dump_req(dump_req), .resume(resume),
        .halt(halt), .rf_rd_idx(rf_rd_idx), .rf_rd_data(rf_rd_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_idx(dump_idx), .dump_last(dump_last),
        .done(done)
    );

    assign rf_rd_data = regs[rf_rd_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a dump emits every register in index order, last flag on the final one.
    task automatic push_expected();
        for (int i = 0; i < NUM_REGS; i++) begin
            exp_t e;
            e.data = regs[i];
            e.idx  = IDX_W'(i);
            e.last = (i == NUM_REGS - 1);
            expq.push_back(e);
        end
    endtask

    task automatic fill_regs(input bit randomize_vals);
        for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] = randomize_vals ? DATA_W'($urandom) : DATA_W'(16'h1000 + i);
        end
    endtask

    // Drive ready (always / stall at idx 4 / random), optionally spray resume, until done.
    task automatic run_dump(input int mode, input bit noise, output int stalls);
        bit fin;
        fin    = 1'b0;
        stalls = 0;
        for (int c = 0; c < 400 && !fin; c++) begin
            case (mode)
                0: dump_ready = 1'b1;
                1: begin
                    if (dump_valid && dump_idx == 4'd4 && stalls < 3) begin
                        dump_ready = 1'b0;
                        stalls++;
                    end else begin
                        dump_ready = 1'b1;
                    end
                end
                default: dump_ready = 1'($urandom_range(0, 1));
            endcase
            if (noise) resume = 1'($urandom_range(0, 1));
            tick();
            resume = 1'b0;
            chk("halt_during_dump", halt, 1);
            if (done) fin = 1'b1;
        end
        dump_ready = 1'b1;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL dump_timeout: got done=%0b expected 1 within 400 cycles", done);
        end
    endtask

    task automatic do_resume();
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("halt_after_resume", halt, 0);
        chk("done_after_resume", done, 0);
    endtask

    // Monitor: a transfer happens at the next posedge when valid&&ready at this negedge.
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic [IDX_W-1:0]  prev_idx;
    logic              prev_last;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!dump_valid || dump_data !== prev_data || dump_idx !== prev_idx || dump_last !== prev_last) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%0b d=%h i=%0d l=%0b expected v=1 d=%h i=%0d l=%0b",
                             dump_valid, dump_data, dump_idx, dump_last, prev_data, prev_idx, prev_last);
                end
            end
            if (dump_valid && dump_ready) begin
                checks++;
                xfer_count++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got idx=%0d data=%h expected no word", dump_idx, dump_data);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    if (dump_data !== e.data || dump_idx !== e.idx || dump_last !== e.last) begin
                        errors++;
                        $display("FAIL word: got d=%h i=%0d l=%0b expected d=%h i=%0d l=%0b",
                                 dump_data, dump_idx, dump_last, e.data, e.idx, e.last);
                    end
                end
            end
            prev_stall = dump_valid && !dump_ready;
            prev_data  = dump_data;
            prev_idx   = dump_idx;
            prev_last  = dump_last;
        end
    end

    initial begin
        int stalls;
        int base;
        rst        = 1'b1;
        bp_en      = 1'b0;
        bp_addr    = 16'd50;
        pc_next    = 16'd50;
        dump_req   = 1'b0;
        resume     = 1'b0;
        dump_ready = 1'b1;
        fill_regs(1'b0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_halt", halt, 0);
        chk("rst_valid", dump_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_data", dump_data, 0);
        chk("rst_idx", dump_idx, 0);
        chk("rst_last", dump_last, 0);
        chk("rst_rd_idx", rf_rd_idx, 0);

        // Disabled breakpoint sitting on a matching PC.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("dis_bp_halt", halt, 0);
            chk("dis_bp_valid", dump_valid, 0);
        end

        // Breakpoint dump with ready always high, exact cycle timing.
        push_expected();
        base  = xfer_count;
        bp_en = 1'b1;
        tick();
        chk("bp_halt_T1", halt, 1);
        chk("bp_valid_T1", dump_valid, 0);
        tick();
        chk("bp_valid_T2", dump_valid, 1);
        chk("bp_idx_T2", dump_idx, 0);
        chk("bp_data_T2", dump_data, 16'h1000);
        for (int i = 1; i < NUM_REGS; i++) begin
            tick();
            chk("bp_valid_run", dump_valid, 1);
            chk("bp_idx_run", dump_idx, i);
            chk("bp_last_run", dump_last, (i == NUM_REGS - 1) ? 1 : 0);
        end
        tick();
        chk("bp_done_T18", done, 1);
        chk("bp_valid_T18", dump_valid, 0);
        chk("bp_halt_T18", halt, 1);
        chk("bp_xfers", xfer_count - base, NUM_REGS);

        // Resume at the same PC must not retrigger.
        do_resume();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no_retrigger_halt", halt, 0);
            chk("no_retrigger_valid", dump_valid, 0);
        end

        // Move off and back onto the breakpoint: second dump, with backpressure at idx 4.
        pc_next = 16'd52;
        tick();
        chk("rearm_halt", halt, 0);
        pc_next = 16'd50;
        push_expected();
        base = xfer_count;
        tick();
        chk("rearm_trigger_halt", halt, 1);
        run_dump(1, 1'b0, stalls);
        chk("bp_stall_cycles", stalls, 3);
        chk("bp2_xfers", xfer_count - base, NUM_REGS);
        do_resume();

        // Manual request with resume noise during the dump and random ready.
        bp_en = 1'b0;
        fill_regs(1'b1);
        push_expected();
        base     = xfer_count;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        chk("man_halt", halt, 1);
        run_dump(2, 1'b1, stalls);
        chk("man_xfers", xfer_count - base, NUM_REGS);
        do_resume();

        // Reset after index 7 transfers.
        fill_regs(1'b1);
        push_expected();
        base       = xfer_count;
        dump_ready = 1'b1;
        dump_req   = 1'b1;
        tick();
        dump_req = 1'b0;
        for (int c = 0; c < 100 && (xfer_count - base) < 8; c++) tick();
        chk("mid_xfers", xfer_count - base, 8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_halt", halt, 0);
        chk("mid_rst_valid", dump_valid, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_idx", dump_idx, 0);
        chk("mid_rst_pending", expq.size(), NUM_REGS - 8);
        expq.delete();
        fill_regs(1'b1);
        push_expected();
        base     = xfer_count;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        run_dump(2, 1'b0, stalls);
        chk("restart_xfers", xfer_count - base, NUM_REGS);
        do_resume();

        // Randomised dumps from random breakpoints or manual requests.
        for (int k = 0; k < 4; k++) begin
            fill_regs(1'b1);
            base = xfer_count;
            if ($urandom_range(0, 1) == 1) begin
                bp_addr = PC_W'($urandom);
                pc_next = bp_addr + 1'b1;
                bp_en   = 1'b1;
                tick();
                push_expected();
                pc_next = bp_addr;
                tick();
            end else begin
                push_expected();
                dump_req = 1'b1;
                tick();
                dump_req = 1'b0;
            end
            chk("rand_halt", halt, 1);
            run_dump(2, 1'b1, stalls);
            chk("rand_xfers", xfer_count - base, NUM_REGS);
            do_resume();
            bp_en = 1'b0;
        end

        tick();
        tick();
        chk("queue_empty", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
